// File: rtl/hps_uart_tx_arbiter.sv
// Round-robin arbiter sharing the HPS UART1 TX byte path among fabric requesters.
// Optional per-message source tag byte: define HPS_UART_ARB_TAG_EN.
module hps_uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic                   o_tx_valid,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_last,
    input  logic                   i_tx_ready,
    output logic [NUM_REQ-1:0]     o_grant
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TAG  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   gidx, gidx_n;
    logic [IW-1:0]   rr_ptr, rr_n;
    logic [IW-1:0]   gidx_inc;
    logic [BW-1:0]   burst_cnt, cnt_n;
    logic [BW-1:0]   cnt_inc;
    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] grant_vec;
    logic [NUM_REQ-1:0] ready_vec;
    logic            pick_hit;
    logic [IW-1:0]   pick_idx;
    int              pick_sum;
    logic            vld_g;
    logic            last_g;
    logic [7:0]      data_g;
    logic            hit_max;
    logic            rel_g;

    // Rotate requests so bit 0 corresponds to the round-robin pointer.
    assign rot = NUM_REQ'({i_req_valid, i_req_valid} >> rr_ptr);

    // Owner's stream signals selected by shifting, grant and ready decoded.
    assign vld_g     = 1'(i_req_valid >> gidx);
    assign last_g    = 1'(i_req_last >> gidx);
    assign data_g    = 8'(i_req_data >> {gidx, 3'b000});
    assign grant_vec = NUM_REQ'(1) << gidx;
    assign ready_vec = NUM_REQ'(i_tx_ready) << gidx;
    assign cnt_inc   = burst_cnt + BW'(1);
    assign hit_max   = (cnt_inc == BW'(MAX_BURST));
    assign rel_g     = last_g | hit_max;
    assign gidx_inc  = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        pick_hit = 1'b0;
        pick_idx = '0;
        pick_sum = 0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                pick_hit = 1'b1;
                pick_sum = int'(rr_ptr) + j;
                if (pick_sum >= NUM_REQ) begin
                    pick_sum = pick_sum - NUM_REQ;
                end
                pick_idx = IW'(pick_sum);
            end
        end
    end

    // State, owner, pointer and burst counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            gidx      <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_n;
            gidx      <= gidx_n;
            rr_ptr    <= rr_n;
            burst_cnt <= cnt_n;
        end
    end

    // Next-state and output decode; outputs are all zero in IDLE.
    always_comb begin
        state_n     = state;
        gidx_n      = gidx;
        rr_n        = rr_ptr;
        cnt_n       = burst_cnt;
        o_tx_valid  = 1'b0;
        o_tx_data   = 8'h00;
        o_tx_last   = 1'b0;
        o_req_ready = '0;
        o_grant     = '0;
        unique case (state)
            S_IDLE: begin
                if (pick_hit) begin
                    gidx_n = pick_idx;
                    cnt_n  = '0;
`ifdef HPS_UART_ARB_TAG_EN
                    state_n = S_TAG;
`else
                    state_n = S_XFER;
`endif
                end
            end
`ifdef HPS_UART_ARB_TAG_EN
            S_TAG: begin
                o_grant    = grant_vec;
                o_tx_valid = 1'b1;
                o_tx_data  = {4'hA, 4'(gidx)};
                if (i_tx_ready) begin
                    state_n = S_XFER;
                end
            end
`endif
            S_XFER: begin
                o_grant     = grant_vec;
                o_tx_valid  = vld_g;
                o_tx_data   = data_g;
                o_tx_last   = vld_g & rel_g;
                o_req_ready = ready_vec;
                if (vld_g && i_tx_ready) begin
                    cnt_n = cnt_inc;
                    if (rel_g) begin
                        state_n = S_IDLE;
                        rr_n    = gidx_inc;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hps_uart_tx_arbiter.sv
// Bench for hps_uart_tx_arbiter: table vectors, directed sequences and a
// randomized run checked against a message-level round-robin model.
module tb_hps_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int MB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            tx_last;
    logic            tx_ready;
    logic [NR-1:0]   grant;

    hps_uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_tx_valid  (tx_valid),
        .o_tx_data   (tx_data),
        .o_tx_last   (tx_last),
        .i_tx_ready  (tx_ready),
        .o_grant     (grant)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct {
        int         g;
        logic [7:0] d;
        logic       l;
    } xfer_t;

    typedef struct packed {
        logic       vld;
        logic [7:0] d;
        logic       l;
        logic       rdy;
        logic       e_vld;
        logic [7:0] e_d;
        logic       e_l;
        logic [3:0] e_g;
        logic [3:0] e_r;
    } vec_t;

    beat_t         rq[NR][$];
    beat_t         mq[NR][$];
    xfer_t         obs[$];
    xfer_t         exp_q[$];
    logic [NR-1:0] gtrace[$];
    logic [NR-1:0] gexp[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    function automatic int owner(input logic [NR-1:0] g);
        for (int k = 0; k < NR; k++) begin
            if (g == (4'b0001 << k)) return k;
        end
        return -1;
    endfunction

    function automatic bit busy();
        for (int k = 0; k < NR; k++) begin
            if (rq[k].size() != 0) return 1'b1;
        end
        return (grant != '0);
    endfunction

    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            if (rq[k].size() != 0) begin
                req_valid[k]       = 1'b1;
                req_data[8*k +: 8] = rq[k][0].d;
                req_last[k]        = rq[k][0].l;
            end else begin
                req_valid[k]       = 1'b0;
                req_data[8*k +: 8] = 8'h00;
                req_last[k]        = 1'b0;
            end
        end
    endtask

    task automatic step(input bit rdy);
        xfer_t x;
        @(negedge clk);
        drive();
        tx_ready = rdy;
        #2;
        gtrace.push_back(grant);
        if (tx_valid && tx_ready) begin
            x.g = owner(grant);
            x.d = tx_data;
            x.l = tx_last;
            obs.push_back(x);
        end
        for (int k = 0; k < NR; k++) begin
            if (req_ready[k] && req_valid[k]) void'(rq[k].pop_front());
        end
    endtask

    task automatic drain(input int pct, input int budget);
        int n;
        n = 0;
        do begin
            step($urandom_range(0, 99) < pct);
            n++;
        end while (busy() && n < budget);
        if (busy()) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: actual busy after %0d cycles required idle", n);
        end
    endtask

    task automatic ex(input int g, input logic [7:0] d, input logic l);
        xfer_t x;
        x.g = g;
        x.d = d;
        x.l = l;
        exp_q.push_back(x);
    endtask

    task automatic ex_tag(input int g);
`ifdef HPS_UART_ARB_TAG_EN
        ex(g, 8'hA0 | 8'(g), 1'b0);
`else
        if (g < 0) ex(g, 8'h00, 1'b0);
`endif
    endtask

    task automatic compare_lists(input string nm);
        chk({nm, "_count"}, 32'(obs.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs[i].g != exp_q[i].g || obs[i].d !== exp_q[i].d ||
                obs[i].l !== exp_q[i].l) begin
                n_bad++;
                $display("FAIL %s[%0d]: actual g%0d %02h last%0b required g%0d %02h last%0b",
                         nm, i, obs[i].g, obs[i].d, obs[i].l,
                         exp_q[i].g, exp_q[i].d, exp_q[i].l);
            end
        end
        obs.delete();
        exp_q.delete();
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t  tbl[$];
        vec_t  v;
        beat_t b;
        int    order[4];
        int    ptr;
        int    g;
        int    n;
        int    len;
        bit    any;
        bit    rel;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        #3;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_last", 32'(tx_last), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester 1: 0x11, 0x22, 0x33 (last).
        tbl.push_back({1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000});
`ifdef HPS_UART_ARB_TAG_EN
        tbl.push_back({1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0, 4'b0010, 4'b0000});
`endif
        tbl.push_back({1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 4'b0010, 4'b0010});
        tbl.push_back({1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 4'b0010, 4'b0010});
        tbl.push_back({1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 4'b0010, 4'b0010});
        tbl.push_back({1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000});
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            req_valid = {2'b00, v.vld, 1'b0};
            req_data  = {16'h0000, v.d, 8'h00};
            req_last  = {2'b00, v.l, 1'b0};
            tx_ready  = v.rdy;
            #2;
            n_cmp++;
            if (tx_valid !== v.e_vld || tx_data !== v.e_d || tx_last !== v.e_l ||
                grant !== v.e_g || req_ready !== v.e_r) begin
                n_bad++;
                $display("FAIL table[%0d]: actual v%0b d%02h l%0b g%04b r%04b required v%0b d%02h l%0b g%04b r%04b",
                         i, tx_valid, tx_data, tx_last, grant, req_ready,
                         v.e_vld, v.e_d, v.e_l, v.e_g, v.e_r);
            end
        end

        // Round robin between requesters 0 and 2, pointer now at 2.
        gtrace.delete();
        obs.delete();
        b.l = 1'b1;
        for (int i = 0; i < 2; i++) begin
            b.d = 8'h50;
            rq[0].push_back(b);
            b.d = 8'h52;
            rq[2].push_back(b);
        end
        drain(100, 200);
        order = '{2, 0, 2, 0};
        gexp.delete();
        for (int i = 0; i < 4; i++) begin
            gexp.push_back(4'b0000);
`ifdef HPS_UART_ARB_TAG_EN
            gexp.push_back(4'b0001 << order[i]);
`endif
            gexp.push_back(4'b0001 << order[i]);
            ex_tag(order[i]);
            ex(order[i], (order[i] == 0) ? 8'h50 : 8'h52, 1'b1);
        end
        gexp.push_back(4'b0000);
        chk("rr_trace_len", 32'(gtrace.size()), 32'(gexp.size()));
        for (int i = 0; i < gtrace.size() && i < gexp.size(); i++) begin
            chk($sformatf("rr_grant[%0d]", i), 32'(gtrace[i]), 32'(gexp[i]));
        end
        compare_lists("rr_stream");

        // Burst limit: requester 3 sends 6 bytes with MAX_BURST = 4.
        for (int i = 1; i <= 6; i++) begin
            b.d = 8'h30 + 8'(i);
            b.l = (i == 6);
            rq[3].push_back(b);
        end
        drain(100, 200);
        ex_tag(3);
        ex(3, 8'h31, 1'b0);
        ex(3, 8'h32, 1'b0);
        ex(3, 8'h33, 1'b0);
        ex(3, 8'h34, 1'b1);
        ex_tag(3);
        ex(3, 8'h35, 1'b0);
        ex(3, 8'h36, 1'b1);
        compare_lists("burst");

        // Backpressure during a 2-byte message from requester 2.
        b.d = 8'h61;
        b.l = 1'b0;
        rq[2].push_back(b);
        b.d = 8'h62;
        b.l = 1'b1;
        rq[2].push_back(b);
        step(1'b1);
`ifdef HPS_UART_ARB_TAG_EN
        step(1'b1);
        chk("bp_tag", 32'(tx_data), 32'hA2);
`endif
        step(1'b1);
        chk("bp_d0", 32'(tx_data), 32'h61);
        chk("bp_r0", 32'(req_ready), 32'b0100);
        step(1'b0);
        chk("bp_d1a", 32'(tx_data), 32'h62);
        chk("bp_r1a", 32'(req_ready), 32'b0000);
        chk("bp_v1a", 32'(tx_valid), 32'd1);
        step(1'b0);
        chk("bp_d1b", 32'(tx_data), 32'h62);
        chk("bp_r1b", 32'(req_ready), 32'b0000);
        step(1'b1);
        chk("bp_d1c", 32'(tx_data), 32'h62);
        chk("bp_r1c", 32'(req_ready), 32'b0100);
        chk("bp_last", 32'(tx_last), 32'd1);
        step(1'b1);
        chk("bp_idle", 32'(grant), 32'd0);
        ex_tag(2);
        ex(2, 8'h61, 1'b0);
        ex(2, 8'h62, 1'b1);
        compare_lists("bp_stream");

        // Reset during byte 2 of 5 from requester 1.
        for (int i = 1; i <= 5; i++) begin
            b.d = 8'h70 + 8'(i);
            b.l = (i == 5);
            rq[1].push_back(b);
        end
        step(1'b1);
`ifdef HPS_UART_ARB_TAG_EN
        step(1'b1);
`endif
        step(1'b1);
        @(negedge clk);
        drive();
        tx_ready = 1'b1;
        #2;
        chk("rst_mid_pre", 32'(tx_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(tx_valid), 32'd0);
        chk("rst_mid_grant", 32'(grant), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd0);
        chk("rst_mid_data", 32'(tx_data), 32'd0);
        chk("rst_mid_last", 32'(tx_last), 32'd0);
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        obs.delete();
        b.d = 8'h81;
        b.l = 1'b1;
        rq[3].push_back(b);
        drain(100, 200);
        chk("rst_first_owner", 32'((obs.size() > 0) ? obs[0].g : -1), 32'd1);
        ex_tag(1);
        ex(1, 8'h72, 1'b0);
        ex(1, 8'h73, 1'b0);
        ex(1, 8'h74, 1'b0);
        ex(1, 8'h75, 1'b1);
        ex_tag(3);
        ex(3, 8'h81, 1'b1);
        compare_lists("rst_stream");

        // Randomized messages against a message-level round-robin model.
        rst_pulse();
        obs.delete();
        for (int m = 0; m < 40; m++) begin
            g   = $urandom_range(0, NR - 1);
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) begin
                b.d = 8'($urandom);
                b.l = (i == len - 1);
                rq[g].push_back(b);
            end
        end
        for (int k = 0; k < NR; k++) mq[k] = rq[k];
        ptr = 0;
        do begin
            any = 1'b0;
            g   = -1;
            for (int i = 0; i < NR; i++) begin
                if (!any && mq[(ptr + i) % NR].size() != 0) begin
                    any = 1'b1;
                    g   = (ptr + i) % NR;
                end
            end
            if (any) begin
                ex_tag(g);
                n = 0;
                do begin
                    b = mq[g].pop_front();
                    n++;
                    rel = b.l || (n == MB);
                    ex(g, b.d, rel);
                end while (!rel);
                ptr = (g + 1) % NR;
            end
        end while (any);
        drain(70, 5000);
        compare_lists("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
